// File: rtl/systolic_job_scheduler.sv
// Round-robin job scheduler in front of a shared 2x2 systolic matmul array.
// Latches one job's operands, times the array window and returns a tagged result.
module systolic_job_scheduler #(
  parameter int NREQ         = 2,
  parameter int DATA_WIDTH   = 4,
  parameter int ACC_WIDTH    = 9,
  parameter int LOAD_CYCLES  = 6,
  parameter int TIMEOUT      = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int IDW          = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*4*DATA_WIDTH-1:0] req_a,
  input  logic [NREQ*4*DATA_WIDTH-1:0] req_b,
  output logic                         arr_in_valid,
  output logic [4*DATA_WIDTH-1:0]      arr_a,
  output logic [4*DATA_WIDTH-1:0]      arr_b,
  input  logic                         arr_out_valid,
  input  logic [4*ACC_WIDTH-1:0]       arr_c,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDW-1:0]               rsp_id,
  output logic [4*ACC_WIDTH-1:0]       rsp_c,
  output logic                         rsp_err,
  output logic                         busy
);

  // state | meaning
  // IDLE  | waiting for a request, grants combinationally
  // LOAD  | array in_valid held, result capture not yet armed
  // WAIT  | in_valid held, capturing on out_valid or timing out
  // RESP  | response presented until rsp_ready
  // DRAIN | in_valid low so the array empties before the next grant
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP, S_DRAIN} state_t;

  localparam int OPW = 4*DATA_WIDTH;
  localparam int RW  = 4*ACC_WIDTH;
  localparam logic [7:0] LOAD_LAST  = 8'(LOAD_CYCLES-1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT-1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES-1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d, id_q, id_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [RW-1:0]   c_q, c_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] req_rot, grant_vec;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx, rr_next;
  int              grant_off, grant_sum, next_sum;

  // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
  always_comb begin
    req_rot   = NREQ'({req_valid, req_valid} >> rr_q);
    grant_any = 1'b0;
    grant_off = 0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_any = 1'b1;
        grant_off = i;
      end
    end
    grant_sum = int'(rr_q) + grant_off;
    if (grant_sum >= NREQ) grant_sum = grant_sum - NREQ;
    next_sum = grant_sum + 1;
    if (next_sum >= NREQ) next_sum = 0;
    grant_idx = IDW'(grant_sum);
    rr_next   = IDW'(next_sum);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    err_d     = err_q;
    grant_vec = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          grant_vec = NREQ'(1) << grant_idx;
          a_d       = req_a[grant_idx*OPW +: OPW];
          b_d       = req_b[grant_idx*OPW +: OPW];
          id_d      = grant_idx;
          rr_d      = rr_next;
          cnt_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (arr_out_valid) begin
          c_d     = arr_c;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          c_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // Grant is combinational from IDLE, so mask it while reset is held.
  assign req_ready    = rstn ? grant_vec : '0;
  assign arr_in_valid = (state_q == S_LOAD) || (state_q == S_WAIT);
  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign arr_a        = a_q;
  assign arr_b        = b_q;
  assign rsp_id       = id_q;
  assign rsp_c        = c_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Randomized bench for systolic_job_scheduler: jobs predicted cycle by cycle
// from the round-robin rule, matrix product and LOAD/TIMEOUT/DRAIN timing.
module tb_systolic_job_scheduler;

  localparam int NREQ  = 2;
  localparam int DW    = 4;
  localparam int AW    = 9;
  localparam int LOADC = 6;
  localparam int TO    = 32;
  localparam int DRC   = 2;
  localparam int IDW   = 1;
  localparam int OPW   = 4*DW;
  localparam int RW    = 4*AW;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*OPW-1:0]  req_a, req_b;
  logic                 arr_in_valid, arr_out_valid;
  logic [OPW-1:0]       arr_a, arr_b;
  logic [RW-1:0]        arr_c;
  logic                 rsp_valid, rsp_ready, rsp_err, busy;
  logic [IDW-1:0]       rsp_id;
  logic [RW-1:0]        rsp_c;

  systolic_job_scheduler #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LOAD_CYCLES(LOADC),
    .TIMEOUT(TO), .DRAIN_CYCLES(DRC), .IDW(IDW)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .arr_in_valid(arr_in_valid), .arr_a(arr_a),
    .arr_b(arr_b), .arr_out_valid(arr_out_valid), .arr_c(arr_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] stat(input logic b, input logic iv, input logic rv,
                                       input logic [NREQ-1:0] rdy);
    return 64'({b, iv, rv, rdy});
  endfunction

  // Matrices as [[m00,m01],[m10,m11]], packed {m11,m10,m01,m00}.
  function automatic logic [RW-1:0] matmul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    int ae[4];
    int be[4];
    logic [RW-1:0] c;
    for (int i = 0; i < 4; i++) begin
      ae[i] = int'(a[i*DW +: DW]);
      be[i] = int'(b[i*DW +: DW]);
    end
    c[0*AW +: AW] = AW'(ae[0]*be[0] + ae[1]*be[2]);
    c[1*AW +: AW] = AW'(ae[0]*be[1] + ae[1]*be[3]);
    c[2*AW +: AW] = AW'(ae[2]*be[0] + ae[3]*be[2]);
    c[3*AW +: AW] = AW'(ae[2]*be[1] + ae[3]*be[3]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_valid pulse on WAIT cycle d; 1: never; 2: only during LOAD.
  // abort_k >= 0 pulses reset at that cycle after grant.
  task automatic run_job(input logic [NREQ-1:0] pat, input int mode, input int d,
                         input int hold, input int abort_k, input bit fixed);
    logic [OPW-1:0]  av[NREQ];
    logic [OPW-1:0]  bv[NREQ];
    logic [NREQ-1:0] tmp;
    logic [RW-1:0]   cexp;
    int g, exp_k, idx;
    bit ok;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = OPW'($urandom);
      bv[i] = OPW'($urandom);
    end
    if (fixed) begin
      av[0] = {DW'(4), DW'(3), DW'(2), DW'(1)};
      bv[0] = {DW'(8), DW'(7), DW'(6), DW'(5)};
    end
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*OPW +: OPW] = av[i];
      req_b[i*OPW +: OPW] = bv[i];
    end
    req_valid = pat;
    #1;
    if (pat == '0) begin
      chk("idle_noreq", stat(busy, arr_in_valid, rsp_valid, req_ready), stat(0, 0, 0, '0));
      tick();
      return;
    end
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      idx = (rr_m + i) % NREQ;
      tmp = pat >> idx;
      if (g < 0 && tmp[0]) g = idx;
    end
    rr_m = (g + 1) % NREQ;
    chk("grant", stat(busy, arr_in_valid, rsp_valid, req_ready), stat(0, 0, 0, NREQ'(1) << g));
    ok    = (mode == 0);
    exp_k = ok ? LOADC + 1 + d : LOADC + TO;
    cexp  = ok ? matmul(av[g], bv[g]) : '0;
    arr_c = ok ? matmul(av[g], bv[g]) : RW'({$urandom, $urandom});
    tick();
    req_a = {NREQ{OPW'($urandom)}};
    req_b = {NREQ{OPW'($urandom)}};
    chk("arr_a_latched", 64'(arr_a), 64'(av[g]));
    chk("arr_b_latched", 64'(arr_b), 64'(bv[g]));
    for (int k = 0; k < exp_k; k++) begin
      if (k > 0) tick();
      arr_out_valid = (mode == 0 && k == LOADC + d) || (mode == 2 && k < LOADC);
      chk("run", stat(busy, arr_in_valid, rsp_valid, req_ready), stat(1, 1, 0, '0));
      if (k == abort_k) begin
        rstn = 1'b0;
        #1;
        chk("rst_ops", {arr_a, arr_b}, '0);
        chk("rst_ctl", {stat(busy, arr_in_valid, rsp_valid, req_ready), rsp_id, rsp_c, rsp_err}, '0);
        arr_out_valid = 1'b0;
        rr_m = 0;
        #1;
        rstn = 1'b1;
        return;
      end
    end
    tick();
    arr_out_valid = 1'b0;
    chk("rsp_stat", stat(busy, arr_in_valid, rsp_valid, req_ready), stat(1, 0, 1, '0));
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_c", 64'(rsp_c), 64'(cexp));
    chk("rsp_err", 64'(rsp_err), 64'(!ok));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_stat", stat(busy, arr_in_valid, rsp_valid, req_ready), stat(1, 0, 1, '0));
      chk("hold_rsp", {rsp_id, rsp_c, rsp_err}, {IDW'(g), cexp, !ok});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int dd = 0; dd < DRC; dd++) begin
      if (dd > 0) tick();
      chk("drain", stat(busy, arr_in_valid, rsp_valid, req_ready), stat(1, 0, 0, '0));
    end
    tick();
  endtask

  initial begin
    int x, m, dly;
    rstn          = 1'b0;
    req_valid     = '1;
    req_a         = '0;
    req_b         = '0;
    arr_out_valid = 1'b0;
    arr_c         = '0;
    rsp_ready     = 1'b0;
    #12;
    chk("reset_ops", {arr_a, arr_b}, '0);
    chk("reset_ctl", {stat(busy, arr_in_valid, rsp_valid, req_ready), rsp_id, rsp_c, rsp_err}, '0);
    rstn = 1'b1;

    run_job(2'b01, 0, 0, 0, -1, 1'b1);
    for (int j = 0; j < 4; j++) run_job(2'b11, 0, j, 0, -1, 1'b0);
    run_job(2'b11, 1, 0, 0, -1, 1'b0);
    run_job(2'b11, 0, 3, 10, -1, 1'b0);
    run_job(2'b10, 0, TO-1, 0, -1, 1'b0);
    run_job(2'b11, 2, 0, 1, -1, 1'b0);
    run_job(2'b01, 1, 0, 0, LOADC+2, 1'b0);
    run_job(2'b11, 0, 0, 0, -1, 1'b1);
    run_job(2'b00, 0, 0, 0, -1, 1'b0);

    for (int j = 0; j < 25; j++) begin
      x   = $urandom_range(0, 9);
      m   = (x < 7) ? 0 : ((x < 9) ? 2 : 1);
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO-1) : $urandom_range(0, 3);
      run_job(NREQ'($urandom_range(0, 3)), m, dly, $urandom_range(0, 3), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
